// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD encoder and the display digit path.
// Digit 0 (ones) always lives in the lowest nibble of a packed BCD vector.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_e;

  localparam int BCD_NIBBLE = 4;

  // Smallest digit count whose decimal range covers every WIDTH-bit unsigned value.
  function automatic int min_digits(input int width);
    logic [63:0] max_val;
    logic [63:0] pow10;
    int          d;
    max_val = (64'd1 << width) - 64'd1;
    pow10   = 64'd10;
    d       = 1;
    for (int i = 0; i < 19; i++) begin
      if (pow10 <= max_val) begin
        pow10 = pow10 * 64'd10;
        d     = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: a digit of 5..9 gets +3 so that the following
// left shift carries correctly into the next decimal digit.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_NIBBLE-1:0] digit_i,
  output logic [BCD_NIBBLE-1:0] digit_o
);

  // Add 3 to digits of 5 or more; the input never exceeds 9, so no carry-out.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end else begin
      digit_o = digit_i;
    end
  end

endmodule

// File: rtl/bin_to_bcd_encoder.sv
// Sequential binary-to-BCD encoder (shift-add-3). Optional two's-complement
// input: the sign is reported on neg and the magnitude is encoded.
module bin_to_bcd_encoder
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [WIDTH-1:0]             bin_in,
  input  logic                         signed_mode,
  output logic                         busy,
  output logic                         done,
  output logic                         neg,
  output logic [BCD_NIBBLE*DIGITS-1:0] bcd_out
);

  localparam int ACC_W = BCD_NIBBLE * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  if (DIGITS < min_digits(WIDTH)) begin : g_digits_check
    $error("bin_to_bcd_encoder: DIGITS too small for WIDTH");
  end

  bcd_state_e          state_q, state_d;
  logic [WIDTH-1:0]    mag_q, mag_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sign_q, sign_d;
  logic [ACC_W-1:0]    bcd_q, bcd_d;
  logic                neg_q, neg_d;

  logic [ACC_W-1:0]       adj_s;
  logic [ACC_W+WIDTH-1:0] shifted_s;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (acc_q[g*BCD_NIBBLE +: BCD_NIBBLE]),
      .digit_o (adj_s[g*BCD_NIBBLE +: BCD_NIBBLE])
    );
  end

  assign shifted_s = {adj_s, mag_q} << 1;

  // Next-state and datapath update for the IDLE / SHIFT / DONE sequence.
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (signed_mode && bin_in[WIDTH-1]) begin
            mag_d  = ~bin_in + WIDTH'(1);
            sign_d = 1'b1;
          end else begin
            mag_d  = bin_in;
            sign_d = 1'b0;
          end
          acc_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        acc_d = shifted_s[ACC_W+WIDTH-1:WIDTH];
        mag_d = shifted_s[WIDTH-1:0];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Publish the finished digits as DONE is entered; never mid-conversion.
          bcd_d   = shifted_s[ACC_W+WIDTH-1:WIDTH];
          neg_d   = sign_q;
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset overrides any conversion in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mag_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign neg     = neg_q;
  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_encoder.sv
// Self-checking bench for bin_to_bcd_encoder (WIDTH=8, DIGITS=3).
// Expected results are queued when a start is accepted and checked on done.
module tb_bin_to_bcd_encoder;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  typedef struct packed {
    logic [11:0] bcd;
    logic        neg;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  bin_in;
  logic        signed_mode;
  logic        busy;
  logic        done;
  logic        neg;
  logic [11:0] bcd_out;

  exp_t sb_q[$];
  int   errors     = 0;
  int   checks     = 0;
  int   done_count = 0;

  always #5 clk = ~clk;

  bin_to_bcd_encoder #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bin_in      (bin_in),
    .signed_mode (signed_mode),
    .busy        (busy),
    .done        (done),
    .neg         (neg),
    .bcd_out     (bcd_out)
  );

  // Decimal reference: digits by division, sign from two's-complement MSB.
  function automatic exp_t model(input logic [7:0] v, input logic sm);
    exp_t e;
    int   m;
    if (sm && v[7]) begin
      m     = 256 - int'(v);
      e.neg = 1'b1;
    end else begin
      m     = int'(v);
      e.neg = 1'b0;
    end
    e.bcd = {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    return e;
  endfunction

  // Scoreboard: on every done pulse pop the oldest expectation and compare.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic bad_digit;
    if (done === 1'b1) begin
      done_count++;
      checks++;
      bad_digit = (bcd_out[3:0] > 4'd9) || (bcd_out[7:4] > 4'd9) || (bcd_out[11:8] > 4'd9);
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: bcd_out=%h neg=%b, required no done pulse", bcd_out, neg);
      end else begin
        e = sb_q.pop_front();
        if (bcd_out !== e.bcd || neg !== e.neg || bad_digit) begin
          errors++;
          $display("FAIL result: bcd_out=%h neg=%b, required bcd_out=%h neg=%b", bcd_out, neg, e.bcd, e.neg);
        end
      end
    end
  end

  // Present one start at a negedge, queue its expectation, drop start after one edge.
  task automatic start_conv(input logic [7:0] v, input logic sm);
    bin_in      = v;
    signed_mode = sm;
    start       = 1'b1;
    sb_q.push_back(model(v, sm));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full conversion with latency check, returning in IDLE.
  task automatic convert(input logic [7:0] v, input logic sm);
    int n;
    start_conv(v, sm);
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != WIDTH + 1) begin
      errors++;
      $display("FAIL latency v=%0d sm=%0b: done after %0d cycles, required %0d", v, sm, n, WIDTH + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    bin_in = 8'd0;
    signed_mode = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, neg, bcd_out} !== 15'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b neg=%b bcd_out=%h, required all zero", busy, done, neg, bcd_out);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_zero_latency();
    int busy_n;
    int done_n;
    int done_at;
    busy_n = 0; done_n = 0; done_at = 0;
    start_conv(8'd0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin
        done_n++;
        done_at = k;
      end
      @(negedge clk);
    end
    checks++;
    if (done_at != WIDTH + 1) begin
      errors++;
      $display("FAIL zero_done_cycle: done at cycle %0d, required %0d", done_at, WIDTH + 1);
    end
    checks++;
    if (done_n != 1) begin
      errors++;
      $display("FAIL zero_done_width: %0d done cycles, required 1", done_n);
    end
    checks++;
    if (busy_n != WIDTH + 1) begin
      errors++;
      $display("FAIL zero_busy_cycles: busy for %0d cycles, required %0d", busy_n, WIDTH + 1);
    end
  endtask

  task automatic test_unsigned();
    int n;
    convert(8'd255, 1'b0);
    // bcd_out must hold the previous result for the whole conversion of 99.
    start_conv(8'd99, 1'b0);
    for (int k = 1; k <= WIDTH; k++) begin
      checks++;
      if (bcd_out !== 12'h255 || neg !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: bcd_out=%h neg=%b, required bcd_out=255 neg=0", k, bcd_out, neg);
      end
      @(negedge clk);
    end
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL hold_done: done %0d cycles late, required 0", n);
    end
    @(negedge clk);
    convert(8'd100, 1'b0);
  endtask

  task automatic test_signed();
    convert(8'h80, 1'b1);
    convert(8'hFF, 1'b1);
    convert(8'h7F, 1'b1);
    convert(8'h80, 1'b0);
  endtask

  task automatic test_back_to_back();
    int dc0;
    int done_at;
    dc0 = done_count;
    done_at = 0;
    start_conv(8'd42, 1'b0);
    for (int k = 1; k <= WIDTH + 1; k++) begin
      if (done === 1'b1) done_at = k;
      if (k == 3 || k == WIDTH + 1) begin
        bin_in      = 8'd200;
        signed_mode = 1'b1;
        start       = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (done_at != WIDTH + 1 || done_count != dc0 + 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start: done_at=%0d dones=%0d busy=%b, required done_at=%0d dones=1 busy=0",
               done_at, done_count - dc0, busy, WIDTH + 1);
    end
    // Start right after DONE is accepted.
    start_conv(8'd7, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL start_after_done: busy=%b, required 1", busy);
    end
    repeat (WIDTH + 1) @(negedge clk);
    checks++;
    if (done_count != dc0 + 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL second_conv: dones=%0d busy=%b, required dones=2 busy=0", done_count - dc0, busy);
    end
  endtask

  task automatic test_reset_mid();
    int dc0;
    start_conv(8'd123, 1'b0);
    repeat (3) @(negedge clk);
    dc0 = done_count;
    reset = 1'b1;
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, done, neg, bcd_out} !== 15'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b neg=%b bcd_out=%h, required all zero", busy, done, neg, bcd_out);
    end
    repeat (15) @(negedge clk);
    checks++;
    if (done_count != dc0) begin
      errors++;
      $display("FAIL reset_mid_done: %0d done pulses, required 0", done_count - dc0);
    end
    // reset and start together: reset wins, start is lost.
    bin_in = 8'd55;
    start  = 1'b1;
    reset  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_with_start: busy=%b, required 0", busy);
    end
    convert(8'd77, 1'b0);
  endtask

  task automatic test_sweep();
    for (int sm = 0; sm < 2; sm++) begin
      for (int v = 0; v < 256; v++) begin
        convert(8'(v), 1'(sm));
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_latency();
    test_unsigned();
    test_signed();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
